uart_alu_if: RTL
================

UART_ALU_IF -- requirements
Module: uart_alu_if

Interface
REQ-001 The block SHALL have the parameter DBIT, default 8, giving the data byte and operand width.
REQ-002 The block SHALL have the parameter NB_OP, default 6, giving the opcode width (taken from r_data[NB_OP-1:0]).
REQ-003 The block SHALL have the parameter TIMEOUT, default 500000, giving the number of idle i_clk cycles allowed between bytes of one frame.
REQ-004 The block SHALL have the parameter TO_BITS, default 19, giving the timeout counter width (2^TO_BITS >= TIMEOUT).
REQ-005 The block SHALL have one clock and synchronous active-low reset, listed first: i_clk  in  1  clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset  in  1  synchronous reset, active-low.
REQ-007 The block SHALL have port rx_empty  in  1  receive FIFO empty flag.
REQ-008 The block SHALL have port r_data  in  DBIT  receive FIFO head byte, valid while rx_empty=0.
REQ-009 The block SHALL have port rd_uart  out  1  receive FIFO pop strobe.
REQ-010 The block SHALL have port tx_full  in  1  transmit FIFO full flag.
REQ-011 The block SHALL have port wr_uart  out  1  transmit FIFO push strobe.
REQ-012 The block SHALL have port w_data  out  DBIT  byte pushed to the transmit FIFO.
REQ-013 The block SHALL have ports o_data_a, o_data_b  out  DBIT each  registered ALU operands.
REQ-014 The block SHALL have port o_opcode  out  NB_OP  registered ALU opcode.
REQ-015 The block SHALL have port i_alu_result  in  DBIT  combinational ALU result.
REQ-016 The block SHALL have port o_busy  out  1  high whenever a frame is in progress (state != GET_A).
REQ-017 The block SHALL have port o_timeout  out  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-018 The block SHALL implement a state machine with the states GET_A, GET_B, GET_OP, EXEC and SEND.
REQ-019 In each GET_* state with rx_empty=0, the block SHALL:
- assert rd_uart in that same cycle;
- capture r_data into the state's register (o_data_a, o_data_b or o_opcode) on that edge;
- advance GET_A->GET_B->GET_OP->EXEC.
REQ-020 In each GET_* state with rx_empty=1, the block SHALL keep rd_uart=0 and hold its state.
REQ-021 rd_uart SHALL be 1 for at most one cycle per byte and never while rx_empty=1.
REQ-022 EXEC SHALL last exactly one cycle:
- the result register captures i_alu_result, with operands already stable for one full cycle;
- the next state is SEND.
REQ-023 In SEND with tx_full=0, the block SHALL assert wr_uart for one cycle with w_data equal to the result register, then go to GET_A.
REQ-024 In SEND with tx_full=1, the block SHALL hold SEND with wr_uart=0 indefinitely (no timeout in SEND).
REQ-025 w_data SHALL equal the result register at all times.
REQ-026 o_data_a, o_data_b and o_opcode SHALL hold their values until recaptured.
REQ-027 Latency from the third-byte pop to wr_uart SHALL be 2 cycles when tx_full=0.
REQ-028 The timeout counter SHALL clear in GET_A, EXEC and SEND, and on every accepted byte.
REQ-029 In GET_B and GET_OP, the timeout counter SHALL increment each cycle that rx_empty=1.
REQ-030 When the counter reaches TIMEOUT-1 in GET_B or GET_OP, the block SHALL:
- pulse o_timeout for one cycle;
- return to GET_A and clear the counter;
- leave the operand registers unchanged.
REQ-031 If a byte is available in the same cycle the counter reaches TIMEOUT-1, the byte SHALL be accepted and no timeout SHALL occur.
REQ-032 The block SHALL support back-to-back frames: a byte present on the cycle after wr_uart (in GET_A) SHALL be popped immediately.

Reset
REQ-033 While reset=0, the block SHALL force each output as follows:
- rd_uart=0, wr_uart=0 and o_timeout=0 combinationally;
- state=GET_A;
- o_data_a, o_data_b, o_opcode, result register, w_data and timeout counter = 0;
- o_busy=0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame without popping or pushing any further byte.
REQ-035 FIFO contents SHALL NOT be flushed by this block's reset.

Verification
REQ-036 Basic frame: FIFO model holds 0x05, 0x03, 0x20 and the ALU model performs ADD -> three single-cycle rd_uart pulses, o_data_a=0x05, o_data_b=0x03, o_opcode=0x20, then wr_uart with w_data=0x08 two cycles after the last pop.
REQ-037 Backpressure: tx_full=1 for 10 cycles at SEND -> wr_uart=0 throughout, then w_data pushed exactly once after tx_full falls.
REQ-038 Timeout: TIMEOUT=16, send only 0x11 and wait 16 idle cycles -> o_timeout single pulse, o_busy=0, next three bytes treated as a fresh frame.
REQ-039 Timeout race: the second byte arrives on the cycle the counter hits 15 -> byte accepted, no o_timeout.
REQ-040 Back-to-back: six bytes preloaded (two frames) -> two wr_uart pulses with correct results and no idle GET_A cycle while data is present.
REQ-041 Reset mid-frame: reset=0 in GET_OP -> all outputs zero, state GET_A, and the remaining FIFO byte is popped as byte A after release.

Source files
------------

// File: rtl/uart_alu_if.sv
// uart_alu_if: collects operand A, operand B and opcode bytes from a UART RX FIFO,
// presents them to an external ALU, and pushes the registered result into the TX FIFO.
module uart_alu_if #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned NB_OP   = 6,
  parameter int unsigned TIMEOUT = 500000,
  parameter int unsigned TO_BITS = 19
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [DBIT-1:0]  r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [DBIT-1:0]  w_data,
  output logic [DBIT-1:0]  o_data_a,
  output logic [DBIT-1:0]  o_data_b,
  output logic [NB_OP-1:0] o_opcode,
  input  logic [DBIT-1:0]  i_alu_result,
  output logic             o_busy,
  output logic             o_timeout
);

  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DBIT-1:0]    a_q, a_d;
  logic [DBIT-1:0]    b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [DBIT-1:0]    res_q, res_d;
  logic [TO_BITS-1:0] cnt_q, cnt_d;
  logic               rd_c, wr_c, to_c;

  // Opcode uses only the low NB_OP bits of the received byte.
  generate
    if (DBIT > NB_OP) begin : g_rdata_hi
      logic unused_rdata_hi;
      assign unused_rdata_hi = ^r_data[DBIT-1:NB_OP];
    end
  endgenerate

  // Next-state, capture and strobe logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    cnt_d   = '0;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    to_c    = 1'b0;
    case (state_q)
      GET_A: begin
        if (!rx_empty) begin
          rd_c    = 1'b1;
          a_d     = r_data;
          state_d = GET_B;
        end
      end
      GET_B, GET_OP: begin
        if (!rx_empty) begin
          rd_c = 1'b1;
          if (state_q == GET_B) begin
            b_d     = r_data;
            state_d = GET_OP;
          end else begin
            op_d    = r_data[NB_OP-1:0];
            state_d = EXEC;
          end
        end else if (cnt_q == TO_LAST) begin
          // A byte arriving on the last allowed cycle wins over the timeout.
          to_c    = 1'b1;
          state_d = GET_A;
        end else begin
          cnt_d = cnt_q + TO_BITS'(1);
        end
      end
      EXEC: begin
        res_d   = i_alu_result;
        state_d = SEND;
      end
      SEND: begin
        if (!tx_full) begin
          wr_c    = 1'b1;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO strobes must act in the same cycle, so they are gated by reset directly.
  assign rd_uart   = reset & rd_c;
  assign wr_uart   = reset & wr_c;
  assign o_timeout = reset & to_c;
  assign o_busy    = reset & (state_q != GET_A);
  assign w_data    = res_q;
  assign o_data_a  = a_q;
  assign o_data_b  = b_q;
  assign o_opcode  = op_q;

endmodule
